// File: rtl/fetch_unit_pkg.sv
// Shared RV32I fetch-side definitions used by the fetch unit and its buffer.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  // One buffered fetch: the instruction word and the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: DEPTH-entry circular buffer of {pc, instr} with push/pop/flush.
// Flush wins over a simultaneous push. DEPTH must be a power of two.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  output fetch_entry_t           head_entry,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign empty      = (count_q == '0);
  assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage. Owns the PC, issues word fetches, buffers returned
// instructions and hands them to decode with a valid/ready handshake.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_bubble_cnt
`endif
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   live_q, live_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [SW-1:0]   occ_sum;
  logic [SW-1:0]   flight_sum;
  logic            accept;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target;

  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // Decode-side view: show-ahead head of the buffer, NOP/0 when empty.
  always_comb begin
    if_valid = !fifo_empty;
    if_instr = fifo_empty ? INSTR_NOP : head_entry.instr;
    if_pc    = fifo_empty ? '0 : head_entry.pc;
    pop      = !fifo_empty && id_ready;
  end

  // Issue credits, response accounting, PC and redirect handling.
  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    live_d     = live_q;
    drop_d     = drop_q;
    target     = word_align(redirect_pc);
    occ_sum    = SW'(fifo_count) + SW'(live_q);
    flight_sum = SW'(live_q) + SW'(drop_q);

    imem_req_valid = rst_n && (occ_sum < SW'(BUF_DEPTH)) &&
                     (flight_sum < SW'(BUF_DEPTH)) && !redirect_valid;
    imem_req_addr  = pc_q;
    accept         = imem_req_valid && imem_req_ready;

    rsp_drop = imem_rsp_valid && (drop_q != '0);
    rsp_keep = imem_rsp_valid && (drop_q == '0) && (live_q != '0);
    push     = rsp_keep && !redirect_valid;

    push_entry.pc    = rsp_pc_q;
    push_entry.instr = imem_rsp_data;

    if (redirect_valid) begin
      pc_d     = target;
      rsp_pc_d = target;
      live_d   = '0;
      // Every outstanding request becomes stale; a response landing this
      // cycle retires one of them whether it was live or already stale.
      drop_d   = CW'(flight_sum - SW'(rsp_keep || rsp_drop));
    end else begin
      if (accept) begin
        pc_d = pc_q + PC_STEP;
      end
      if (rsp_drop) begin
        drop_d = drop_q - CW'(1);
      end
      if (rsp_keep) begin
        rsp_pc_d = rsp_pc_q + PC_STEP;
      end
      live_d = CW'(SW'(live_q) + SW'(accept) - SW'(rsp_keep));
    end
  end

  // PC and in-flight counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      live_q   <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      live_q   <= live_d;
      drop_q   <= drop_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Count consumed instructions and cycles where decode waits on fetch.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + 32'(pop);
    bubble_cnt_d = bubble_cnt_q + 32'(id_ready && fifo_empty);
  end

  // Performance counter registers; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic, with a
// queue-based scoreboard of the expected decode stream and request addresses.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  fetch_unit #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Stimulus knobs.
  int unsigned lat_min = 1, lat_max = 1, rdy_pct = 100, idr_pct = 100, redir_pct = 0;

  // Reference model: program-order fetch stream restarted by reset/redirect.
  logic [31:0] exp_q[$];
  logic [31:0] exp_next;
  logic [31:0] req_next;

  // Memory model: accepted requests answered in order after their latency.
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;
  mreq_t       mem_q[$];
  int unsigned tcyc     = 0;
  int unsigned last_due = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_restart(input logic [31:0] start);
    exp_q.delete();
    exp_next = {start[31:2], 2'b00};
    req_next = {start[31:2], 2'b00};
  endtask

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_next);
      exp_next = exp_next + 32'd4;
    end
  endtask

  // One clock cycle of stimulus: inputs applied at the falling edge.
  task automatic step(input bit rst, input bit force_redir, input logic [31:0] tgt);
    int unsigned lat, due;
    logic [31:0] r;
    @(negedge clk);
    tcyc++;
    rst_n          = !rst;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!rst && mem_q.size() > 0 && mem_q[0].due <= tcyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    id_ready       = !rst && ($urandom_range(99) < idr_pct);
    redirect_valid = !rst && (force_redir || (redir_pct != 0 && $urandom_range(99) < redir_pct));
    r = $urandom;
    if (force_redir) redirect_pc = tgt;
    else if (r[1:0] == 2'b00) redirect_pc = 32'hFFFF_FFF0 | {28'd0, r[7:4]};
    else redirect_pc = $urandom;
    #1;
    if (rst) begin
      mem_q.delete();
      last_due = tcyc;
    end else if (imem_req_valid && imem_req_ready) begin
      lat = $urandom_range(lat_max, lat_min);
      due = tcyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{addr: imem_req_addr, due: due});
    end
    #2;
    if (rst) model_restart(RST_PC);
    else if (redirect_valid) model_restart(redirect_pc);
    topup();
  endtask

  // Monitor: compares requests and decode handoffs against the model.
  bit          prev_rst = 1'b0;
  int unsigned m_pops   = 0;
  int unsigned m_bub    = 0;
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1) begin
        if (imem_req_valid && imem_req_ready) begin
          check("req_addr", imem_req_addr, req_next);
          req_next = req_next + 32'd4;
        end
        if (redirect_valid) check("req_during_redirect", {31'd0, imem_req_valid}, 32'd0);
        if (!if_valid) check("idle_instr", if_instr, NOP);
`ifdef FETCH_PERF_EN
        check("perf_fetch_cnt", perf_fetch_cnt, m_pops);
        check("perf_bubble_cnt", perf_bubble_cnt, m_bub);
        if (id_ready && !if_valid) m_bub++;
`endif
        if (if_valid && id_ready) begin
          m_pops++;
          if (exp_q.size() == 0) begin
            check("exp_queue_empty", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("if_pc", if_pc, e);
            check("if_instr", if_instr, mem_word(e));
          end
        end
      end else begin
        if (prev_rst) begin
          check("rst_if_valid", {31'd0, if_valid}, 32'd0);
          check("rst_if_instr", if_instr, NOP);
          check("rst_if_pc", if_pc, 32'd0);
          check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
`ifdef FETCH_PERF_EN
          check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
          check("rst_perf_bubble", perf_bubble_cnt, 32'd0);
`endif
        end
        m_pops = 0;
        m_bub  = 0;
      end
      prev_rst = (rst_n === 1'b0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cfg(input int unsigned lmin, input int unsigned lmax, input int unsigned rdy,
                     input int unsigned idr, input int unsigned rdr);
    lat_min = lmin; lat_max = lmax; rdy_pct = rdy; idr_pct = idr; redir_pct = rdr;
  endtask

  initial begin
    int unsigned first_valid, bubbles, accepts, rpops;
    logic [31:0] addrs[$];
    logic [31:0] first_pc;
    bit          seen;

    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    model_restart(RST_PC);
    topup();

    // Streaming with 1-cycle memory; fill latency, no bubbles, PC wrap.
    cfg(1, 1, 100, 100, 0);
    repeat (3) step(1, 0, '0);
    first_valid = 0; bubbles = 0;
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, '0);
      if (imem_req_valid && imem_req_ready) addrs.push_back(imem_req_addr);
      if (if_valid && first_valid == 0) first_valid = i;
      if (i >= 3 && !if_valid) bubbles++;
    end
    check("t1_first_valid_cycle", first_valid, 32'd3);
    check("t1_bubbles", bubbles, 32'd0);
    check("t5_addr0", addrs[0], 32'hFFFF_FFF8);
    check("t5_addr1", addrs[1], 32'hFFFF_FFFC);
    check("t5_addr2", addrs[2], 32'h0000_0000);

    // Decode stalled: requests stop at the buffer depth, order kept on release.
    cfg(1, 1, 100, 0, 0);
    repeat (2) step(1, 0, '0);
    accepts = 0;
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, '0);
      if (imem_req_valid && imem_req_ready) accepts++;
    end
    check("t2_accepts", accepts, DEPTH);
    check("t2_req_valid_off", {31'd0, imem_req_valid}, 32'd0);
    check("t2_head_pc", if_pc, RST_PC);
    cfg(1, 1, 100, 100, 0);
    repeat (12) step(0, 0, '0);

    // Redirect with two requests in flight on a 3-cycle memory.
    cfg(3, 3, 100, 100, 0);
    repeat (2) step(1, 0, '0);
    accepts = 0;
    for (int i = 1; i <= 2; i++) begin
      step(0, 0, '0);
      if (imem_req_valid && imem_req_ready) accepts++;
    end
    check("t3_in_flight", accepts, 32'd2);
    step(0, 1, 32'h0000_0100);
    step(0, 0, '0);
    check("t3_drop_count", 32'(dut.drop_q), 32'd2);
    seen = 1'b0; first_pc = '0;
    for (int i = 0; i < 15; i++) begin
      if (if_valid && !seen) begin seen = 1'b1; first_pc = if_pc; end
      step(0, 0, '0);
    end
    check("t3_first_pc", first_pc, 32'h0000_0100);

    // Redirect coinciding with a response and a pop.
    cfg(1, 1, 100, 100, 0);
    repeat (2) step(1, 0, '0);
    repeat (5) step(0, 0, '0);
    step(0, 1, 32'h0000_0203);
    check("t4_setup", {29'd0, imem_rsp_valid, if_valid, id_ready}, 32'd7);
    step(0, 0, '0);
    check("t4_if_valid_next", {31'd0, if_valid}, 32'd0);
    check("t4_drop_count", 32'(dut.drop_q), 32'd0);
    check("t4_live_count", 32'(dut.live_q), 32'd0);
    repeat (10) step(0, 0, '0);

    // Randomized traffic with a mid-run reset.
    cfg(1, 4, 70, 70, 4);
    repeat (2) step(1, 0, '0);
    rpops = 0;
    for (int i = 0; i < 3000; i++) begin
      step((i == 1500) || (i == 1501), 0, '0);
      if (rst_n && if_valid && id_ready) rpops++;
    end
    check("rand_progress", {31'd0, (rpops > 300)}, 32'd1);
    cfg(1, 1, 100, 100, 0);
    repeat (5) step(0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
